// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//   Round-robin arbiter that lets two requesters share one external 8-bit
//   combinational logical barrel shifter (zero fill, 0..7 positions per pass).
//   Shift amounts of 8..15 are carried out in two passes: a fixed 7-position
//   pre-shift, then the remainder. One operation is in flight at a time.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   req0_valid/data/amt/dir       requester 0 operation (dir 1 = right)
//   req0_ready                    requester 0 accepted this cycle
//   req1_*                        same set for requester 1
//   sh_in, sh_select, sh_control  operand / amount / direction to the shifter
//   sh_out                        shifter result (same cycle)
//   rsp_valid, rsp_data, rsp_id   result handshake toward the consumer
//   rsp_ready                     consumer accepts the result
//   busy                          high whenever the FSM is not in IDLE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrate, accept one request, register its fields
// PRE   | first pass of a two-pass shift (7 positions), keep partial
// SHIFT | final pass (remainder or full amount), capture result
// RESP  | present result until rsp_ready, then update last_grant
// -----------------------------------------------------------------------------
module shift_arbiter (
  input  logic       clk,
  input  logic       rst,

  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic [3:0] req0_amt,
  input  logic       req0_dir,
  output logic       req0_ready,

  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic [3:0] req1_amt,
  input  logic       req1_dir,
  output logic       req1_ready,

  output logic [7:0] sh_in,
  output logic [2:0] sh_select,
  output logic       sh_control,
  input  logic [7:0] sh_out,

  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  input  logic       rsp_ready,

  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [7:0] op_q;
  logic [3:0] amt_q;
  logic       dir_q;
  logic       id_q;
  logic [3:0] rem_q;
  logic       last_grant_q;
  logic [7:0] rsp_data_q;

  logic       grant_id;
  logic       accept;
  logic [7:0] sel_data;
  logic [3:0] sel_amt;
  logic       sel_dir;
  logic [2:0] rem_select;

  // ---------------------------------------------------------------------------
  // Arbitration: a lone requester always wins; on contention the requester
  // that did not own the last completed operation wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = req1_valid;
    end
  end

  // Readies must stay low while reset is held even though the state register
  // already reads IDLE, so reset gates acceptance directly.
  assign accept = (state == IDLE) && (req0_valid || req1_valid) && !rst;

  always_comb begin
    if (grant_id) begin
      sel_data = req1_data;
      sel_amt  = req1_amt;
      sel_dir  = req1_dir;
    end else begin
      sel_data = req0_data;
      sel_amt  = req0_amt;
      sel_dir  = req0_dir;
    end
  end

  // amt = 15 leaves a remainder of 8, which the 3-bit shifter select cannot
  // express. The total shift is already >= 8 in that case, so any second pass
  // of 7 still yields all zeros; clamping keeps the result exact.
  assign rem_select = (rem_q > 4'd7) ? 3'd7 : rem_q[2:0];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    sh_in      = 8'h00;
    sh_select  = 3'd0;
    sh_control = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = (sel_amt > 4'd7) ? PRE : SHIFT;
        end
      end

      PRE: begin
        sh_in      = op_q;
        sh_select  = 3'd7;
        sh_control = dir_q;
        state_nxt  = SHIFT;
      end

      SHIFT: begin
        sh_in      = op_q;
        sh_control = dir_q;
        sh_select  = amt_q[3] ? rem_select : amt_q[2:0];
        state_nxt  = RESP;
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= 8'h00;
      amt_q        <= 4'd0;
      dir_q        <= 1'b0;
      id_q         <= 1'b0;
      rem_q        <= 4'd0;
      last_grant_q <= 1'b1;
      rsp_data_q   <= 8'h00;
    end else begin
      if (accept) begin
        op_q  <= sel_data;
        amt_q <= sel_amt;
        dir_q <= sel_dir;
        id_q  <= grant_id;
      end

      if (state == PRE) begin
        op_q  <= sh_out;
        rem_q <= amt_q - 4'd7;
      end

      if (state == SHIFT) begin
        rsp_data_q <= sh_out;
      end

      if ((state == RESP) && rsp_ready) begin
        last_grant_q <= id_q;
      end
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_id   = id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//   Directed bench for shift_arbiter. Provides a behavioural model of the
//   external zero-fill barrel shifter and compares DUT outputs against
//   hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic [3:0] req0_amt;
  logic       req0_dir;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic [3:0] req1_amt;
  logic       req1_dir;
  logic       req1_ready;
  logic [7:0] sh_in;
  logic [2:0] sh_select;
  logic       sh_control;
  logic [7:0] sh_out;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_id;
  logic       rsp_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;

  shift_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_dir   (req0_dir),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_dir   (req1_dir),
    .req1_ready (req1_ready),
    .sh_in      (sh_in),
    .sh_select  (sh_select),
    .sh_control (sh_control),
    .sh_out     (sh_out),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // external shared shifter: logical, zero fill
  always_comb sh_out = sh_control ? (sh_in >> sh_select) : (sh_in << sh_select);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 8'h00);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready0"}, req0_ready, 0);
    check({tag, "_ready1"}, req1_ready, 0);
    check({tag, "_sh_in"}, sh_in, 8'h00);
    check({tag, "_sh_select"}, sh_select, 0);
    check({tag, "_sh_control"}, sh_control, 0);
  endtask

  // One operation from a single requester. sel_a/sel_b are the shifter
  // selects expected in the first and (two-pass only) second busy cycle.
  task automatic run_op(input logic id, input logic [7:0] data, input logic [3:0] amt,
                        input logic dir, input logic [7:0] exp_data, input int exp_lat,
                        input logic [2:0] sel_a, input logic [2:0] sel_b, input int hold);
    int         lat;
    int         n;
    logic [2:0] sels [4];
    @(negedge clk);
    rsp_ready = (hold == 0);
    if (id) begin
      req1_valid = 1'b1; req1_data = data; req1_amt = amt; req1_dir = dir;
    end else begin
      req0_valid = 1'b1; req0_data = data; req0_amt = amt; req0_dir = dir;
    end
    #1;
    check("ready_granted", id ? req1_ready : req0_ready, 1);
    check("ready_other", id ? req0_ready : req1_ready, 0);
    @(posedge clk);
    #1;
    // scramble requester inputs; they must not affect the operation
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = ~data; req1_data = ~data;
    req0_amt = ~amt; req1_amt = ~amt;
    req0_dir = ~dir; req1_dir = ~dir;
    lat = 0;
    n = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("first_sh_in", sh_in, data);
        check("first_sh_control", sh_control, dir);
        check("first_busy", busy, 1);
      end
      if (!rsp_valid && n < 4) begin
        sels[n] = sh_select;
        n++;
      end
    end while (!rsp_valid && lat < 8);
    check("latency", lat, exp_lat);
    check("sel_first", sels[0], sel_a);
    if (exp_lat == 3) check("sel_second", sels[1], sel_b);
    check("rsp_data", rsp_data, exp_data);
    check("rsp_id", rsp_id, id);
    check("resp_sh_select", sh_select, 0);
    check("resp_sh_in", sh_in, 8'h00);
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        req0_valid = 1'b1;
        req1_valid = 1'b1;
      end
      #1;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data", rsp_data, exp_data);
      check("hold_rsp_id", rsp_id, id);
      check("hold_busy", busy, 1);
      check("hold_ready0", req0_ready, 0);
      check("hold_ready1", req1_ready, 0);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("after_rsp_valid", rsp_valid, 0);
    check("after_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       grants [4];
    logic       rids [4];
    logic [7:0] rdat [4];
    int         ng;
    int         nr;
    int         cyc;

    rst = 1'b1;
    req0_valid = 1'b0; req0_data = 8'h00; req0_amt = 4'd0; req0_dir = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_amt = 4'd0; req1_dir = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_reset_outputs("reset");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 8'hB5, 4'd3,  1'b0, 8'hA8, 2, 3'd3, 3'd0, 0);
    run_op(1'b1, 8'hF0, 4'd10, 1'b1, 8'h00, 3, 3'd7, 3'd3, 0);
    run_op(1'b0, 8'h80, 4'd7,  1'b1, 8'h01, 2, 3'd7, 3'd0, 0);
    run_op(1'b1, 8'hFF, 4'd15, 1'b0, 8'h00, 3, 3'd7, 3'd7, 0);
    run_op(1'b0, 8'hFF, 4'd8,  1'b1, 8'h00, 3, 3'd7, 3'd1, 0);
    run_op(1'b0, 8'h5A, 4'd0,  1'b1, 8'h5A, 2, 3'd0, 3'd0, 0);
    run_op(1'b1, 8'h3C, 4'd2,  1'b0, 8'hF0, 2, 3'd2, 3'd0, 5);

    // reset during PRE of an amt = 12 operation
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'hFF; req0_amt = 4'd12; req0_dir = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("pre_sh_select", sh_select, 7);
    check("pre_busy", busy, 1);
    rst = 1'b1;
    req0_valid = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("post_rst_no_rsp", rsp_valid, 0);
      @(negedge clk);
    end
    run_op(1'b0, 8'h01, 4'd0, 1'b0, 8'h01, 2, 3'd0, 3'd0, 0);

    // round robin under continuous contention from a fresh reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h81; req0_amt = 4'd1; req0_dir = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h81; req1_amt = 4'd1; req1_dir = 1'b1;
    rsp_ready = 1'b1;
    ng = 0;
    nr = 0;
    cyc = 0;
    while (nr < 4 && cyc < 40) begin
      #1;
      if (req0_ready || req1_ready) begin
        if (ng < 4) grants[ng] = req1_ready;
        ng++;
      end
      if (rsp_valid) begin
        if (nr < 4) begin
          rids[nr] = rsp_id;
          rdat[nr] = rsp_data;
        end
        nr++;
        if (nr == 4) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check("rr_rsp_count", nr, 4);
    check("rr_grant_count", ng, 4);
    for (int i = 0; i < 4; i++) begin
      check("rr_grant", grants[i], i % 2);
      check("rr_rsp_id", rids[i], i % 2);
      check("rr_rsp_data", rdat[i], (i % 2 == 1) ? 8'h40 : 8'h02);
    end
    repeat (3) @(negedge clk);
    check("rr_final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits, shift amount at 4 bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_data / req0_amt / req0_dir  input  8 / 4 / 1  operand, shift amount 0..15, direction (1 = right, 0 = left).
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req1_valid, req1_data, req1_amt, req1_dir, req1_ready  SHALL be identical to the requester 0 ports, for requester 1.
REQ-008 sh_in  output  8  operand driven to the shared 8-bit combinational logical barrel shifter.
REQ-009 sh_select  output  3  shifter amount, 0..7.
REQ-010 sh_control  output  1  shifter direction (1 = right).
REQ-011 sh_out  input  8  shifter result, zero-filled, valid in the same cycle.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_data  output  8  result value.
REQ-014 rsp_id  output  1  index of the requester that owns the result.
REQ-015 rsp_ready  input  1  consumer accepts the result.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, PRE, SHIFT, RESP.
REQ-018 IDLE, arbitration: with exactly one valid, that requester is granted; with both valid, the requester not granted last is granted (round robin via last_grant).
REQ-019 IDLE, acceptance: the granted requester's ready SHALL be high combinationally in that cycle; the other ready stays low; both readies are low in all other states.
REQ-020 On acceptance the block SHALL register operand, amount, direction and id; next state is PRE if amt > 7, else SHIFT.
REQ-021 PRE: drive sh_in = operand register, sh_select = 7, sh_control = dir; capture sh_out into the operand register; store remainder = amt - 7; go to SHIFT.
REQ-022 SHIFT: drive sh_in = operand register, sh_control = dir, and sh_select = remainder (two-pass) or amt[2:0] (single pass); capture sh_out into rsp_data; go to RESP.
REQ-023 RESP: rsp_valid = 1; rsp_data and rsp_id SHALL remain stable until rsp_ready is sampled high.
REQ-024 When rsp_ready is sampled high in RESP, the block SHALL go to IDLE and set last_grant = rsp_id.
REQ-025 In IDLE and RESP, sh_in, sh_select and sh_control SHALL be 0.
REQ-026 Latency: with rsp_ready held high, rsp_valid rises 2 clocks after the acceptance edge for amt <= 7 and 3 clocks after it for amt >= 8.
REQ-027 Throughput: a new acceptance is possible no earlier than the cycle after RESP exits; there is no overlap of operations.
REQ-028 Amount cases:
- amt = 0 returns the operand unchanged.
- amt = 8..15 returns 8'h00 (left or right).
- Direction is never reinterpreted between passes.
REQ-029 Requester inputs are sampled only in the accepting cycle; changes to them while busy SHALL have no effect.
REQ-030 rsp_ready high outside RESP SHALL be ignored.

Reset
REQ-031 While rst is high:
- state = IDLE, rsp_valid = 0, rsp_data = 8'h00, rsp_id = 0, busy = 0;
- both readies = 0, sh_* outputs = 0;
- last_grant = 1, so requester 0 wins the first contention.
REQ-032 rst asserted mid-operation (PRE, SHIFT or RESP) SHALL discard the operation immediately, with no response ever issued for it.

Verification
REQ-033 req0 only, data = 8'hB5, amt = 3, dir = 0, rsp_ready = 1 -> req0_ready pulse, sh_select = 3 in SHIFT, rsp_data = 8'hA8, rsp_id = 0, rsp_valid 2 clocks after acceptance.
REQ-034 req1, data = 8'hF0, amt = 10, dir = 1 -> PRE with sh_select = 7, SHIFT with sh_select = 3, rsp_data = 8'h00, rsp_id = 1, 3-clock latency.
REQ-035 Both requesters valid continuously after reset, each amt = 1 -> grants alternate 0, 1, 0, 1; rsp_id follows the same sequence.
REQ-036 rsp_ready held low for 5 cycles in RESP -> rsp_valid and rsp_data stable, both readies low, busy = 1; accept on the 6th cycle.
REQ-037 rst pulsed during PRE of an amt = 12 operation -> outputs at reset values, no rsp_valid afterwards; the next req0 operation (data = 8'h01, amt = 0) returns 8'h01.
REQ-038 amt = 7, dir = 1, data = 8'h80 -> single pass, sh_select = 7, rsp_data = 8'h01.
